wb_sram_arbiter: RTL and testbench

- Two-master Wishbone arbiter that shares one 32-bit Wishbone slave, the 16-bit SRAM controller, between master 0 (CPU) and master 1 (DMA/video).
- Grants are round-robin and held until the slave ACKs.
- A one-cycle gap after every ACK guarantees the slave's registered ACK has dropped before the next strobe.
- Sits between the masters and the SRAM controller, with no buffering of data.

---
 rtl/wb_arb_pkg.sv | 14 +
 rtl/wb_arb_rr2.sv | 12 +
 rtl/wb_sram_arbiter.sv | 142 ++++++++++++++
 tb/tb_wb_sram_arbiter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the two-master Wishbone SRAM arbiter.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  localparam int unsigned MIDX_W          = 1;
  localparam int unsigned TIMEOUT_DEFAULT = 255;
  localparam int unsigned TO_CNT_W        = 8;

endpackage

// File: rtl/wb_arb_rr2.sv
// Two-requester round-robin picker: on a tie the master not served last wins.
module wb_arb_rr2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       any,
  output logic       pick
);

  assign any  = |req;
  assign pick = (&req) ? ~last : req[1];

endmodule

// File: rtl/wb_sram_arbiter.sv
// Round-robin arbiter sharing the SRAM controller's Wishbone slave between two masters.
// Optional BUSY-state watchdog enabled by defining WB_ARB_TIMEOUT_EN.
module wb_sram_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_stb_i,
  input  logic        m0_cyc_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_adr_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_dat_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic        m1_stb_i,
  input  logic        m1_cyc_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_adr_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_dat_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic        s_stb_o,
  output logic        s_cyc_o,
  output logic        s_we_o,
  output logic [31:0] s_adr_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_dat_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i
);

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("wb_sram_arbiter: TIMEOUT must be in 1..255");
  end

  state_t              state, state_d;
  logic [MIDX_W-1:0]   grant, grant_d;
  logic                last, last_d;
  logic [1:0]          req;
  logic                any, pick;
  logic                busy;
  logic                to_hit;

  assign req = {m1_cyc_i & m1_stb_i, m0_cyc_i & m0_stb_i};

  wb_arb_rr2 u_rr (
    .req  (req),
    .last (last),
    .any  (any),
    .pick (pick)
  );

  // Reset masks the slave strobe combinationally so it drops in the reset cycle itself.
  assign busy = (state == S_BUSY) && !reset;

`ifdef WB_ARB_TIMEOUT_EN
  logic [TO_CNT_W-1:0] cnt;

  assign to_hit = busy && !s_ack_i && (int unsigned'(cnt) == TIMEOUT);

  always_ff @(posedge clk) begin
    if (reset)                         cnt <= '0;
    else if (state == S_IDLE)          cnt <= '0;
    else if (state == S_BUSY && !s_ack_i) cnt <= cnt + 1'b1;
  end
`else
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      grant <= '0;
      last  <= 1'b1;
    end else begin
      state <= state_d;
      grant <= grant_d;
      last  <= last_d;
    end
  end

  always_comb begin
    state_d = state;
    grant_d = grant;
    last_d  = last;
    case (state)
      S_IDLE: begin
        if (any) begin
          grant_d = pick;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        // An aborted master still waits here: the SRAM controller always finishes.
        if (s_ack_i || to_hit) begin
          last_d  = grant;
          state_d = S_GAP;
        end
      end
      S_GAP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    s_stb_o = 1'b0;
    s_cyc_o = 1'b0;
    s_we_o  = 1'b0;
    s_adr_o = m0_adr_i;
    s_sel_o = m0_sel_i;
    s_dat_o = m0_dat_i;
    if (busy) begin
      if (grant == 1'b1) begin
        s_stb_o = m1_stb_i;
        s_cyc_o = m1_cyc_i;
        s_we_o  = m1_we_i;
        s_adr_o = m1_adr_i;
        s_sel_o = m1_sel_i;
        s_dat_o = m1_dat_i;
      end else begin
        s_stb_o = m0_stb_i;
        s_cyc_o = m0_cyc_i;
        s_we_o  = m0_we_i;
      end
    end
  end

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

  assign m0_ack_o = s_ack_i && busy && (grant == 1'b0) && m0_cyc_i;
  assign m1_ack_o = s_ack_i && busy && (grant == 1'b1) && m1_cyc_i;
  assign m0_err_o = to_hit && (grant == 1'b0);
  assign m1_err_o = to_hit && (grant == 1'b1);

endmodule

// File: tb/tb_wb_sram_arbiter.sv
// Directed bench for wb_sram_arbiter; covers the timeout path when WB_ARB_TIMEOUT_EN is defined.
module tb_wb_sram_arbiter;
  import wb_arb_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_stb_i, m0_cyc_i, m0_we_i;
  logic [31:0] m0_adr_i, m0_dat_i, m0_dat_o;
  logic [3:0]  m0_sel_i;
  logic        m0_ack_o, m0_err_o;
  logic        m1_stb_i, m1_cyc_i, m1_we_i;
  logic [31:0] m1_adr_i, m1_dat_i, m1_dat_o;
  logic [3:0]  m1_sel_i;
  logic        m1_ack_o, m1_err_o;
  logic        s_stb_o, s_cyc_o, s_we_o;
  logic [31:0] s_adr_o, s_dat_o, s_dat_i;
  logic [3:0]  s_sel_o;
  logic        s_ack_i;

  int passed = 0;
  int total  = 0;

  wb_sram_arbiter #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .m0_stb_i(m0_stb_i), .m0_cyc_i(m0_cyc_i), .m0_we_i(m0_we_i),
    .m0_adr_i(m0_adr_i), .m0_sel_i(m0_sel_i), .m0_dat_i(m0_dat_i),
    .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_stb_i(m1_stb_i), .m1_cyc_i(m1_cyc_i), .m1_we_i(m1_we_i),
    .m1_adr_i(m1_adr_i), .m1_sel_i(m1_sel_i), .m1_dat_i(m1_dat_i),
    .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o), .s_we_o(s_we_o),
    .s_adr_o(s_adr_o), .s_sel_o(s_sel_o), .s_dat_o(s_dat_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    {m0_stb_i, m0_cyc_i, m0_we_i, m1_stb_i, m1_cyc_i, m1_we_i} = '0;
    m0_adr_i = '0; m0_sel_i = '0; m0_dat_i = '0;
    m1_adr_i = '0; m1_sel_i = '0; m1_dat_i = '0;
    s_dat_i = '0; s_ack_i = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_stb", 32'(s_stb_o), 32'd0);
    chk("rst_state", 32'(dut.state), 32'(S_IDLE));
    chk("rst_last", 32'(dut.last), 32'd1);
    chk("rst_acks", 32'({m1_ack_o, m0_ack_o}), 32'd0);

    // Master 0 read, slave acks 3 cycles after strobe
    reset = 1'b0;
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 32'h100; m0_sel_i = 4'hF;
    #1 chk("t1_idle_stb", 32'(s_stb_o), 32'd0);
    @(negedge clk);
    chk("t1_stb", 32'(s_stb_o), 32'd1);
    chk("t1_adr", s_adr_o, 32'h100);
    chk("t1_we", 32'(s_we_o), 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("t1_noack", 32'(m0_ack_o), 32'd0);
    @(negedge clk);
    s_ack_i = 1'b1; s_dat_i = 32'h1234_5678;
    #1 chk("t1_ack", 32'(m0_ack_o), 32'd1);
    chk("t1_dat", m0_dat_o, 32'h1234_5678);
    chk("t1_m1ack", 32'(m1_ack_o), 32'd0);
    @(negedge clk);
    s_ack_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    chk("t1_gap", 32'(dut.state), 32'(S_GAP));
    chk("t1_ack_once", 32'(m0_ack_o), 32'd0);
    @(negedge clk);
    chk("t1_idle", 32'(dut.state), 32'(S_IDLE));

    // Both masters requesting continuously from reset: 0,1,0,1
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 32'h200;
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_adr_i = 32'h300;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t2_grant", 32'(dut.grant), 32'(k % 2));
      chk("t2_adr", s_adr_o, (k % 2 == 1) ? 32'h300 : 32'h200);
      s_ack_i = 1'b1;
      #1 chk("t2_acks", 32'({m1_ack_o, m0_ack_o}), (k % 2 == 1) ? 32'd2 : 32'd1);
      @(negedge clk);
      s_ack_i = 1'b0;
      chk("t2_gap", 32'(dut.state), 32'(S_GAP));
      chk("t2_gap_stb", 32'(s_stb_o), 32'd0);
      @(negedge clk);
      chk("t2_idle", 32'(dut.state), 32'(S_IDLE));
    end
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;

    // Master 1 write while master 0 waits
    @(negedge clk);
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_we_i = 1'b1;
    m1_sel_i = 4'b0011; m1_dat_i = 32'hDEAD_BEEF; m1_adr_i = 32'h400;
    @(negedge clk);
    chk("t3_we", 32'(s_we_o), 32'd1);
    chk("t3_sel", 32'(s_sel_o), 32'h3);
    chk("t3_dat", s_dat_o, 32'hDEAD_BEEF);
    chk("t3_adr", s_adr_o, 32'h400);
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_we_i = 1'b0; m0_adr_i = 32'h500;
    #1 chk("t3_blocked_adr", s_adr_o, 32'h400);
    @(negedge clk);
    s_ack_i = 1'b1;
    #1 chk("t3_acks", 32'({m1_ack_o, m0_ack_o}), 32'd2);
    @(negedge clk);
    s_ack_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0; m1_we_i = 1'b0;
    chk("t3_gap_stb", 32'(s_stb_o), 32'd0);
    @(negedge clk);
    chk("t3_idle_stb", 32'(s_stb_o), 32'd0);
    @(negedge clk);
    chk("t3_m0_grant", 32'(dut.grant), 32'd0);
    chk("t3_m0_adr", s_adr_o, 32'h500);
    chk("t3_m0_stb", 32'(s_stb_o), 32'd1);
    s_ack_i = 1'b1;
    @(negedge clk);
    s_ack_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    @(negedge clk);

    // Master 0 aborts mid-access; arbiter waits for the slave, then serves master 1
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 32'h600;
    @(negedge clk);
    chk("t4_adr", s_adr_o, 32'h600);
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_adr_i = 32'h700;
    #1 chk("t4_cyc_drop", 32'(s_cyc_o), 32'd0);
    @(negedge clk);
    chk("t4_hold_busy", 32'(dut.state), 32'(S_BUSY));
    s_ack_i = 1'b1;
    #1 chk("t4_no_ack", 32'({m1_ack_o, m0_ack_o}), 32'd0);
    @(negedge clk);
    s_ack_i = 1'b0;
    chk("t4_gap", 32'(dut.state), 32'(S_GAP));
    @(negedge clk);
    @(negedge clk);
    chk("t4_m1_grant", 32'(dut.grant), 32'd1);
    chk("t4_m1_adr", s_adr_o, 32'h700);
    s_ack_i = 1'b1;
    #1 chk("t4_m1_ack", 32'(m1_ack_o), 32'd1);
    @(negedge clk);
    s_ack_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
    @(negedge clk);

    // Reset during BUSY
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 32'h800;
    @(negedge clk);
    chk("t5_busy_stb", 32'(s_stb_o), 32'd1);
    reset = 1'b1; s_ack_i = 1'b1;
    #1 chk("t5_stb_drop", 32'(s_stb_o), 32'd0);
    chk("t5_ack_mask", 32'(m0_ack_o), 32'd0);
    @(negedge clk);
    chk("t5_state", 32'(dut.state), 32'(S_IDLE));
    chk("t5_last", 32'(dut.last), 32'd1);
    reset = 1'b0; s_ack_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;

    // Stray ACK while idle
    @(negedge clk);
    s_ack_i = 1'b1; s_dat_i = 32'hCAFE_F00D;
    #1 chk("t6_stray_acks", 32'({m1_ack_o, m0_ack_o}), 32'd0);
    chk("t6_dat_pass", m1_dat_o, 32'hCAFE_F00D);
    @(negedge clk);
    chk("t6_stay_idle", 32'(dut.state), 32'(S_IDLE));
    s_ack_i = 1'b0;

    // Slave never acks: timeout path, or plain wait without the watchdog
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 32'h900;
    @(negedge clk);
    chk("t7_stb", 32'(s_stb_o), 32'd1);
    chk("t7_err0", 32'(m0_err_o), 32'd0);
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_adr_i = 32'hA00;
`ifdef WB_ARB_TIMEOUT_EN
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      chk("t7_no_err", 32'(m0_err_o), 32'd0);
    end
    @(negedge clk);
    chk("t7_err", 32'({m1_err_o, m0_err_o}), 32'd1);
    @(negedge clk);
    chk("t7_gap", 32'(dut.state), 32'(S_GAP));
    chk("t7_err_pulse", 32'(m0_err_o), 32'd0);
    s_ack_i = 1'b1;
    #1 chk("t7_late_ack", 32'(m0_ack_o), 32'd0);
    @(negedge clk);
    s_ack_i = 1'b0;
`else
    for (int k = 1; k < 6; k++) begin
      @(negedge clk);
      chk("t7_no_err", 32'({m1_err_o, m0_err_o}), 32'd0);
      chk("t7_busy", 32'(dut.state), 32'(S_BUSY));
    end
    s_ack_i = 1'b1;
    @(negedge clk);
    s_ack_i = 1'b0;
    @(negedge clk);
`endif
    @(negedge clk);
    chk("t7_m1_grant", 32'(dut.grant), 32'd1);
    chk("t7_m1_adr", s_adr_o, 32'hA00);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
